uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one fast_8N1_UART_TX between N_REQ byte-stream requesters with message-locked round-robin arbitration.
//  Owns the TX_LOAD/TX_DATA/LOAD_OK handshake. Requesters see a simple valid/ready byte interface with a last flag.
//  Sits between on-chip message sources (debug, status, echo) and the transmitter, all on sys_clk (24 MHz HFOSC).
// PARAMETERS
//  N_REQ       4      number of requesters (2..8)
//  BYTE_W      8      byte width; must match the transmitter
//  WDT_CYCLES  2400   owner-stall limit in sys_clk cycles (used only with UART_ARB_WATCHDOG_EN)
// PORTS
//  sys_clk     in   1              system clock; the only clock
//  rst         in   1              synchronous, active-high reset
//  en          in   1              arbiter enable
//  req_valid   in   N_REQ          requester i has a byte on req_data[i]
//  req_data    in   N_REQ*BYTE_W   packed bytes; requester i uses bits [i*BYTE_W +: BYTE_W]
//  req_last    in   N_REQ          the byte on req_data[i] ends requester i's message
//  req_ready   out  N_REQ          one-cycle pulse: requester i's byte was taken
//  grant       out  N_REQ          one-hot current owner; all-zero when idle
//  tx_load     out  1              to transmitter TX_LOAD; one-cycle pulse
//  tx_data     out  BYTE_W         to transmitter TX_DATA; valid while tx_load=1
//  load_ok     in   1              from transmitter LOAD_OK
//  busy        out  1              grant is nonzero
//  wdt_strobe  out  1              one-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset values: state=IDLE, grant=0, req_ready=0, tx_load=0, tx_data=0, busy=0, wdt_strobe=0, rr_ptr=0.
//  All outputs are registered.
//  FSM states: IDLE, LOAD, WAIT_ACK, WAIT_RDY.
//  IDLE:
//   - If en=1 and req_valid is nonzero: grant the first valid index at or after rr_ptr (cyclic). Go to LOAD.
//   - Arbitration latency is 1 cycle.
//  LOAD:
//   - When en=1, req_valid[owner]=1 and load_ok=1, in the same registered edge: tx_load<=1,
//     tx_data<=req_data[owner], req_ready[owner]<=1, last_q<=req_last[owner]. Go to WAIT_ACK.
//   - Otherwise hold in LOAD.
//  WAIT_ACK: wait for load_ok=0 (transmitter accepted the byte), then go to WAIT_RDY.
//  WAIT_RDY: wait for load_ok=1.
//   - If last_q=0: go to LOAD.
//   - If last_q=1: grant<=0, rr_ptr<=(owner+1) mod N_REQ, go to IDLE.
//  A requester must advance or drop its valid in the cycle it sees req_ready.
//   - A byte is never taken twice: the FSM has already left LOAD by then.
//  The grant is locked for the whole message. Other requesters' valid and data are ignored until the owner's last byte.
//  Simultaneous requests are resolved round-robin. A single-byte message (last=1 on its first byte) is legal.
//  en=0 in IDLE: no grant is issued.
//  en=0 while owned: any byte already loaded completes its handshake; no new byte is taken; the grant is kept.
//  Owner drops req_valid mid-message: grant held, nothing issued (see watchdog).
//  rst mid-operation: immediate return to reset values next cycle. The transmitter is not reset by this block.
//  Any tx_load already issued is not retracted.
// CONFIGURATION
//  UART_ARB_WATCHDOG_EN defined:
//   - A counter runs while in LOAD with req_valid[owner]=0 and clears on any byte taken.
//   - At WDT_CYCLES: grant<=0, rr_ptr<=owner+1, state<=IDLE, wdt_strobe pulses 1 cycle.
//  UART_ARB_WATCHDOG_EN undefined:
//   - No counter; an idle owner holds the grant indefinitely.
//   - wdt_strobe is tied to 0.
// TESTING
//  Single requester "AB"(0x41, 0x42 last):
//   - two tx_load pulses, data 0x41 then 0x42, each after load_ok rises.
//   - grant returns to 0 after the second byte; rr_ptr=1.
//  Req0 and req2 both valid from reset, 2-byte messages each:
//   - output order r0b0, r0b1, r2b0, r2b1; no interleaving; grant 0001 then 0100.
//  Fairness, all 4 requesters continuously sending 1-byte messages:
//   - grant order 0, 1, 2, 3, 0; each index is served exactly once per 4 messages.
//  load_ok held low 100 cycles after the first tx_load:
//   - no further tx_load; the next byte is loaded only after load_ok returns high.
//  Owner drops valid mid-message:
//   - macro on, WDT_CYCLES=16: wdt_strobe pulses once, the next requester is granted.
//   - macro off: grant held.
//  rst pulsed while in WAIT_ACK:
//   - next cycle grant=0, tx_load=0, state IDLE, rr_ptr=0.
//   - a new request is granted 1 cycle after rst falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Purpose : shares one 8N1 UART transmitter between N_REQ requesters, locking the grant for a whole message.
// Latency : grant 1 cycle after a request in IDLE; a byte goes out 1 cycle after LOAD sees valid & load_ok.
// Backpress: load_ok low stalls LOAD/WAIT_RDY; a stalled owner keeps the grant (UART_ARB_WATCHDOG_EN revokes it).
module uart_tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int BYTE_W     = 8,
   parameter int WDT_CYCLES = 2400
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*BYTE_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        grant,
   output logic                    tx_load,
   output logic [BYTE_W-1:0]       tx_data,
   input  logic                    load_ok,
   output logic                    busy,
   output logic                    wdt_strobe
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_RDY} state_t;

   state_t           state;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] rr_ptr;
   logic             last_q;

   logic [PTR_W:0]   cand;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_vld;
   logic             take;
   logic [PTR_W-1:0] owner_nxt;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      cand     = '0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(N_REQ)) begin
            cand = cand - (PTR_W+1)'(N_REQ);
         end
         if (!pick_vld && req_valid[cand[PTR_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[PTR_W-1:0];
         end
      end
   end

   assign take      = en && req_valid[owner] && load_ok;
   assign owner_nxt = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(WDT_CYCLES + 1);
   logic [CNT_W-1:0] wdt_cnt;
   logic             wdt_strobe_q;
   assign wdt_strobe = wdt_strobe_q;
`else
   assign wdt_strobe = 1'b0;
`endif

   // Arbiter FSM with registered handshake outputs; tx_load and req_ready are single-cycle pulses.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         last_q    <= 1'b0;
         grant     <= '0;
         req_ready <= '0;
         tx_load   <= 1'b0;
         tx_data   <= '0;
         busy      <= 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
         wdt_cnt      <= '0;
         wdt_strobe_q <= 1'b0;
`endif
      end else begin
         tx_load   <= 1'b0;
         req_ready <= '0;
`ifdef UART_ARB_WATCHDOG_EN
         wdt_strobe_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (en && pick_vld) begin
                  grant <= N_REQ'(1) << pick_idx;
                  owner <= pick_idx;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (take) begin
                  tx_load          <= 1'b1;
                  tx_data          <= req_data[int'(owner)*BYTE_W +: BYTE_W];
                  req_ready[owner] <= 1'b1;
                  last_q           <= req_last[owner];
                  state            <= WAIT_ACK;
`ifdef UART_ARB_WATCHDOG_EN
                  wdt_cnt          <= '0;
               end else if (!req_valid[owner]) begin
                  // Owner has gone quiet mid-message: release the transmitter after the stall limit.
                  if (wdt_cnt == CNT_W'(WDT_CYCLES - 1)) begin
                     wdt_cnt      <= '0;
                     wdt_strobe_q <= 1'b1;
                     grant        <= '0;
                     busy         <= 1'b0;
                     rr_ptr       <= owner_nxt;
                     state        <= IDLE;
                  end else begin
                     wdt_cnt <= wdt_cnt + 1'b1;
                  end
`endif
               end
            end
            WAIT_ACK: begin
               // load_ok falling means the transmitter latched the byte.
               if (!load_ok) begin
                  state <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (load_ok) begin
                  if (last_q) begin
                     grant  <= '0;
                     busy   <= 1'b0;
                     rr_ptr <= owner_nxt;
                     state  <= IDLE;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: queued requester models, a UART load_ok model and a scoreboard on tx_load.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   typedef struct packed { logic [7:0] d; logic l; } rbyte_t;
   typedef struct packed { logic [3:0] g; logic [7:0] d; } exp_t;

   logic           sys_clk = 1'b0;
   logic           rst;
   logic           en;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           tx_load;
   logic [W-1:0]   tx_data;
   logic           load_ok;
   logic           busy;
   logic           wdt_strobe;

   rbyte_t rq[N][$];
   exp_t   expq[$];
   exp_t   mon_e;

   int vectors     = 0;
   int miscompares = 0;
   int n_loads     = 0;
   int n_strobes   = 0;
   int stall_len   = 3;

   always #20 sys_clk = ~sys_clk;

   uart_tx_arbiter #(.N_REQ(N), .BYTE_W(W), .WDT_CYCLES(16)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .tx_load   (tx_load),
      .tx_data   (tx_data),
      .load_ok   (load_ok),
      .busy      (busy),
      .wdt_strobe(wdt_strobe)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic feed(input int r, input logic [7:0] d, input logic l);
      rbyte_t b;
      b.d = d;
      b.l = l;
      rq[r].push_back(b);
   endtask

   task automatic expect_load(input logic [3:0] g, input logic [7:0] d);
      exp_t e;
      e.g = g;
      e.d = d;
      expq.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = rq[i][0].d;
            req_last[i]        = rq[i][0].l;
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*W +: W] = '0;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while ((expq.size() != 0 || busy) && t < 3000) begin
         tick();
         t++;
      end
      check({name, "_drain"}, (expq.size() != 0 || busy) ? 32'd1 : 32'd0, 32'd0);
   endtask

   task automatic wait_load(input string name);
      int n0;
      int t;
      n0 = n_loads;
      t  = 0;
      while (n_loads == n0 && t < 500) begin
         tick();
         t++;
      end
      check({name, "_load_seen"}, n_loads - n0, 1);
   endtask

   // Requesters: present the head of each queue, pop it when req_ready pulses.
   initial begin
      drive_reqs();
      forever begin
         @(posedge sys_clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         end
         drive_reqs();
      end
   end

   // Transmitter: load_ok drops after each tx_load and returns after stall_len cycles.
   initial begin
      load_ok = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (tx_load) begin
            load_ok = 1'b0;
            repeat (stall_len) @(posedge sys_clk);
            #1;
            load_ok = 1'b1;
         end
      end
   end

   // Monitor: every tx_load must match the next expected (grant, byte) pair.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (tx_load) begin
            n_loads++;
            if (expq.size() > 0) mon_e = expq.pop_front();
            else mon_e = '1;
            check("tx_load", {20'd0, grant, tx_data}, {20'd0, mon_e.g, mon_e.d});
         end
         if (wdt_strobe) n_strobes++;
      end
   end

   initial begin
      repeat (60000) @(posedge sys_clk);
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      int n0;
      int s0;
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) tick();
      check("rst_grant", grant, 0);
      check("rst_tx_load", tx_load, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_wdt_strobe", wdt_strobe, 0);
      rst = 1'b0;

      // "AB" on requester 0, held off by en=0 first.
      en = 1'b0;
      feed(0, 8'h41, 1'b0);
      feed(0, 8'h42, 1'b1);
      expect_load(4'b0001, 8'h41);
      expect_load(4'b0001, 8'h42);
      repeat (6) tick();
      check("en0_no_grant", grant, 0);
      en = 1'b1;
      wait_done("ab");
      check("ab_grant_released", grant, 0);

      // rr_ptr is now 1: requester 1 wins over requester 0.
      feed(0, 8'h50, 1'b1);
      feed(1, 8'h51, 1'b1);
      expect_load(4'b0010, 8'h51);
      expect_load(4'b0001, 8'h50);
      wait_done("rr_ptr1");

      // Requesters 0 and 2 valid from reset, 2-byte messages, no interleaving.
      rst = 1'b1;
      tick();
      feed(0, 8'h10, 1'b0);
      feed(0, 8'h11, 1'b1);
      feed(2, 8'h20, 1'b0);
      feed(2, 8'h21, 1'b1);
      expect_load(4'b0001, 8'h10);
      expect_load(4'b0001, 8'h11);
      expect_load(4'b0100, 8'h20);
      expect_load(4'b0100, 8'h21);
      tick();
      rst = 1'b0;
      tick();
      check("two_first_grant", grant, 4'b0001);
      wait_done("two_msgs");

      // Fairness: all four requesters with two 1-byte messages each.
      rst = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         feed(i, 8'h60 + 8'(i), 1'b1);
         feed(i, 8'h70 + 8'(i), 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            expect_load(4'(1 << i), ((k == 0) ? 8'h60 : 8'h70) + 8'(i));
         end
      end
      tick();
      rst = 1'b0;
      wait_done("fair");

      // load_ok held low for 100 cycles after the first byte.
      stall_len = 100;
      feed(1, 8'h81, 1'b0);
      feed(1, 8'h82, 1'b1);
      expect_load(4'b0010, 8'h81);
      expect_load(4'b0010, 8'h82);
      wait_load("stall_first");
      stall_len = 3;
      cnt = 0;
      n0  = n_loads;
      while (n_loads == n0 && cnt < 300) begin
         tick();
         cnt++;
      end
      check("stall_gap_in_window", (cnt >= 100 && cnt <= 104) ? 32'd1 : 32'd0, 32'd1);
      wait_done("stall");

      // Owner 0 goes quiet after its first (non-last) byte; requester 1 waits.
      s0 = n_strobes;
      feed(0, 8'h90, 1'b0);
      feed(1, 8'h91, 1'b1);
      expect_load(4'b0001, 8'h90);
`ifdef UART_ARB_WATCHDOG_EN
      expect_load(4'b0010, 8'h91);
`endif
      wait_load("wdt_first");
      repeat (40) tick();
`ifdef UART_ARB_WATCHDOG_EN
      check("wdt_strobe_count", n_strobes - s0, 1);
      wait_done("wdt_next");
`else
      check("wdt_off_grant_held", grant, 4'b0001);
      check("wdt_off_busy", busy, 1);
      check("wdt_off_no_strobe", n_strobes - s0, 0);
      rst = 1'b1;
      for (int i = 0; i < N; i++) rq[i].delete();
      tick();
      tick();
      rst = 1'b0;
`endif

      // Move rr_ptr to 2, then reset in WAIT_ACK.
      feed(1, 8'hB1, 1'b1);
      expect_load(4'b0010, 8'hB1);
      wait_done("pre_rst");
      feed(3, 8'hA0, 1'b0);
      feed(3, 8'hA1, 1'b1);
      expect_load(4'b1000, 8'hA0);
      cnt = 0;
      while (!tx_load && cnt < 500) begin
         tick();
         cnt++;
      end
      check("rst_mid_load_seen", tx_load, 1);
      rst = 1'b1;
      rq[3].delete();
      feed(1, 8'hC1, 1'b1);
      feed(2, 8'hC2, 1'b1);
      expect_load(4'b0010, 8'hC1);
      expect_load(4'b0100, 8'hC2);
      tick();
      check("rst_mid_grant", grant, 0);
      check("rst_mid_tx_load", tx_load, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_req_ready", req_ready, 0);
      rst = 1'b0;
      tick();
      check("post_rst_grant", grant, 4'b0010);
      wait_done("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
